// File: rtl/i_cache_nway.sv
// i_cache_nway: N-way set-associative instruction cache with tree pseudo-LRU replacement,
// an uncached fetch path, whole-cache invalidate and error-aware AXI4 read refill.
//
// Lookup is two-stage. F1 presents the address and the tag/data arrays are read
// synchronously. F2 compares tags, returns the hit word and updates PLRU. A miss stalls
// the core until the refill or uncached word comes back through the one-cycle RESP state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_inst_en/addr          F1 fetch request and word-aligned address
//   no_cache                  F1 request bypasses the arrays
//   freeze                    external hold of the F1->F2 registers
//   inv_req                   pulse, invalidate every set
//   i_stall                   core must hold F1/F2
//   cpu_inst_rdata            instruction for the F2 request
//   inv_busy                  invalidate sweep in progress
//   bus_err                   F2 word came back with a non-OKAY response
//   i_ar*/i_r*                AXI4 read address and read data channels
//   hit_cnt, miss_cnt         request counters, present only with I_CACHE_PERF_EN
//
// Optional build macro: I_CACHE_PERF_EN adds the hit/miss counters and their ports.
module i_cache_nway #(
   parameter int unsigned LEN_LINE  = 5,
   parameter int unsigned LEN_INDEX = 7,
   parameter int unsigned NR_WAYS   = 4
) (
   input  logic        clk,
`ifdef I_CACHE_PERF_EN
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
`endif
   input  logic        rst,
   input  logic        cpu_inst_en,
   input  logic [31:0] cpu_inst_addr,
   input  logic        no_cache,
   input  logic        freeze,
   input  logic        inv_req,
   output logic        i_stall,
   output logic [31:0] cpu_inst_rdata,
   output logic        inv_busy,
   output logic        bus_err,
   output logic [31:0] i_araddr,
   output logic [7:0]  i_arlen,
   output logic [2:0]  i_arsize,
   output logic [1:0]  i_arburst,
   output logic        i_arvalid,
   input  logic        i_arready,
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_rresp,
   input  logic        i_rlast,
   input  logic        i_rvalid,
   output logic        i_rready
);

   localparam int unsigned NR_WORDS = 2 ** (LEN_LINE - 2);
   localparam int unsigned LEN_WORD = LEN_LINE - 2;
   localparam int unsigned LEN_TAG  = 32 - LEN_LINE - LEN_INDEX;
   localparam int unsigned NR_SETS  = 2 ** LEN_INDEX;
   localparam int unsigned TAG_LSB  = LEN_LINE + LEN_INDEX;
   localparam int unsigned LEVELS   = $clog2(NR_WAYS);
   localparam int unsigned LEN_WAY  = (NR_WAYS > 1) ? LEVELS : 1;
   localparam int unsigned PLRU_W   = (NR_WAYS > 1) ? NR_WAYS - 1 : 1;

   typedef enum logic [2:0] {StIdle, StRefill, StUncached, StResp, StInval} state_e;

   state_e state_q, state_d;

   // F2 request registers
   logic                 f2_en_q, f2_nc_q;
   logic [31:0]          f2_addr_q;
   logic [LEN_TAG-1:0]   f2_tag;
   logic [LEN_INDEX-1:0] f2_index, f1_index, rd_index;
   logic [LEN_WORD-1:0]  f2_word, f1_word, rd_word;

   // Miss handling registers
   logic                 ar_done_q;
   logic [LEN_WORD-1:0]  cnt_q;
   logic [31:0]          cap_q;
   logic                 err_q;
   logic [LEN_WAY-1:0]   victim_q;
   logic [LEN_INDEX-1:0] inv_cnt_q;
   logic                 inv_pend_q;

   // Per-set state kept in flops so reset and invalidate can clear it
   logic [NR_WAYS-1:0]   valid_q [NR_SETS];
   logic [PLRU_W-1:0]    plru_q  [NR_SETS];

   // Synchronous-read arrays
   logic [LEN_TAG-1:0]   tag_mem  [NR_WAYS][NR_SETS];
   logic [31:0]          data_mem [NR_WAYS][NR_SETS*NR_WORDS];
   logic [LEN_TAG-1:0]   tag_rd   [NR_WAYS];
   logic [31:0]          data_rd  [NR_WAYS];

   logic                 hit, miss, resp_ok, advance;
   logic [LEN_WAY-1:0]   hit_way, vict_sel;
   logic                 r_beat, last_refill_beat, start_fill, start_refill;

   // Walk from the root following the node bits; the leaf reached is the victim.
   function automatic logic [LEN_WAY-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      int n;
      n = 0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         n = 2 * n + 1 + int'(bits[n]);
      end
      return LEN_WAY'(n - int'(NR_WAYS) + 1);
   endfunction

   // Point every node on the way's path away from it.
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [LEN_WAY-1:0] way);
      logic [PLRU_W-1:0] nb;
      int                n;
      logic              d;
      nb = bits;
      n  = 0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         d     = way[int'(LEVELS) - 1 - l];
         nb[n] = ~d;
         n     = 2 * n + 1 + int'(d);
      end
      return nb;
   endfunction

   assign f2_tag   = f2_addr_q[31:TAG_LSB];
   assign f2_index = f2_addr_q[TAG_LSB-1:LEN_LINE];
   assign f2_word  = f2_addr_q[LEN_LINE-1:2];
   assign f1_index = cpu_inst_addr[TAG_LSB-1:LEN_LINE];
   assign f1_word  = cpu_inst_addr[LEN_LINE-1:2];

   assign advance  = ~i_stall & ~freeze;
   // While F2 holds, keep re-reading its own set so array updates become visible.
   assign rd_index = advance ? f1_index : f2_index;
   assign rd_word  = advance ? f1_word : f2_word;

   assign r_beat           = i_rvalid & i_rready;
   assign last_refill_beat = (state_q == StRefill) & r_beat & i_rlast;
   assign start_fill       = (state_q == StIdle) &
                             ((state_d == StRefill) | (state_d == StUncached));
   assign start_refill     = (state_q == StIdle) & (state_d == StRefill);

   // Tag compare; only meaningful while the cache is idle.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < int'(NR_WAYS); w++) begin
         if (valid_q[f2_index][w] && (tag_rd[w] == f2_tag)) begin
            hit     = 1'b1;
            hit_way = LEN_WAY'(w);
         end
      end
      hit  = hit & f2_en_q & ~f2_nc_q & (state_q == StIdle);
      miss = (state_q == StIdle) & f2_en_q & ~hit;
   end

   // Lowest-numbered invalid way wins over the PLRU choice.
   always_comb begin
      vict_sel = plru_victim(plru_q[f2_index]);
      for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[f2_index][w]) begin
            vict_sel = LEN_WAY'(w);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            // Invalidate beats a pending miss; the miss is retried afterwards.
            if (inv_req || inv_pend_q) begin
               state_d = StInval;
            end else if (miss) begin
               state_d = f2_nc_q ? StUncached : StRefill;
            end
         end
         StRefill: begin
            if (r_beat && i_rlast) begin
               state_d = StResp;
            end
         end
         StUncached: begin
            if (r_beat) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (!freeze) begin
               state_d = StIdle;
            end
         end
         StInval: begin
            if (inv_cnt_q == '1) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      i_arvalid = 1'b0;
      i_rready  = 1'b0;
      inv_busy  = 1'b0;
      bus_err   = 1'b0;
      resp_ok   = 1'b0;
      unique case (state_q)
         StRefill, StUncached: begin
            i_arvalid = ~ar_done_q;
            i_rready  = ar_done_q;
         end
         StResp: begin
            resp_ok = 1'b1;
            // Report once, in the cycle the word is actually consumed.
            bus_err = err_q & ~freeze;
         end
         StInval: inv_busy = 1'b1;
         default: ;
      endcase
      i_stall        = (f2_en_q & ~hit & ~resp_ok) | ((state_q != StIdle) & ~resp_ok);
      cpu_inst_rdata = resp_ok ? cap_q : (hit ? data_rd[hit_way] : 32'h0);
      i_araddr       = (state_q == StUncached) ? f2_addr_q
                                               : {f2_addr_q[31:LEN_LINE], {LEN_LINE{1'b0}}};
      i_arlen        = (state_q == StUncached) ? 8'd0 : 8'(NR_WORDS - 1);
      i_arsize       = 3'd2;
      i_arburst      = 2'b01;
   end

   // Array read ports and refill writes
   always_ff @(posedge clk) begin
      for (int w = 0; w < int'(NR_WAYS); w++) begin
         tag_rd[w]  <= tag_mem[w][rd_index];
         data_rd[w] <= data_mem[w][{rd_index, rd_word}];
         if (last_refill_beat && (victim_q == LEN_WAY'(w))) begin
            tag_mem[w][f2_index] <= f2_tag;
         end
         if ((state_q == StRefill) && r_beat && (victim_q == LEN_WAY'(w))) begin
            data_mem[w][{f2_index, cnt_q}] <= i_rdata;
         end
      end
   end

   // Request pipeline, miss datapath, valid and PLRU state
   always_ff @(posedge clk) begin
      if (rst) begin
         f2_en_q    <= 1'b0;
         f2_nc_q    <= 1'b0;
         f2_addr_q  <= '0;
         ar_done_q  <= 1'b0;
         cnt_q      <= '0;
         cap_q      <= '0;
         err_q      <= 1'b0;
         victim_q   <= '0;
         inv_cnt_q  <= '0;
         inv_pend_q <= 1'b0;
         for (int s = 0; s < int'(NR_SETS); s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (advance) begin
            f2_en_q   <= cpu_inst_en;
            f2_nc_q   <= no_cache;
            f2_addr_q <= cpu_inst_addr;
         end
         if (start_fill) begin
            ar_done_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
         end
         if (start_refill) begin
            victim_q                   <= vict_sel;
            valid_q[f2_index][vict_sel] <= 1'b0;
         end
         if (i_arvalid && i_arready) begin
            ar_done_q <= 1'b1;
         end
         if (r_beat) begin
            cnt_q <= cnt_q + 1'b1;
            if ((state_q == StUncached) || (cnt_q == f2_word)) begin
               cap_q <= i_rdata;
            end
            if (i_rresp != 2'b00) begin
               err_q <= 1'b1;
            end
         end
         if (last_refill_beat) begin
            // A line with any bad beat never becomes valid.
            valid_q[f2_index][victim_q] <= ~err_q & (i_rresp == 2'b00);
            plru_q[f2_index]            <= plru_touch(plru_q[f2_index], victim_q);
         end
         if (hit) begin
            plru_q[f2_index] <= plru_touch(plru_q[f2_index], hit_way);
         end
         if (state_q == StInval) begin
            valid_q[inv_cnt_q] <= '0;
            plru_q[inv_cnt_q]  <= '0;
            inv_cnt_q          <= inv_cnt_q + 1'b1;
         end
         // A request that arrives mid-transaction is held until the cache is idle.
         if (inv_req && (state_q != StIdle)) begin
            inv_pend_q <= 1'b1;
         end else if ((state_q == StIdle) && (state_d == StInval)) begin
            inv_pend_q <= 1'b0;
         end
      end
   end

`ifdef I_CACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && !freeze) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (start_refill) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_i_cache_nway.sv
// Directed bench for i_cache_nway: cold refill, hit, PLRU eviction, uncached fetch,
// refill error and whole-cache invalidate, against a small AXI read slave.
module tb_i_cache_nway;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_inst_en;
   logic [31:0] cpu_inst_addr;
   logic        no_cache;
   logic        freeze;
   logic        inv_req;
   logic        i_stall;
   logic [31:0] cpu_inst_rdata;
   logic        inv_busy;
   logic        bus_err;
   logic [31:0] i_araddr;
   logic [7:0]  i_arlen;
   logic [2:0]  i_arsize;
   logic [1:0]  i_arburst;
   logic        i_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        i_rlast;
   logic        i_rvalid;
   logic        i_rready;
`ifdef I_CACHE_PERF_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   always #5 clk = ~clk;

   i_cache_nway dut (
      .clk            (clk),
`ifdef I_CACHE_PERF_EN
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt),
`endif
      .rst            (rst),
      .cpu_inst_en    (cpu_inst_en),
      .cpu_inst_addr  (cpu_inst_addr),
      .no_cache       (no_cache),
      .freeze         (freeze),
      .inv_req        (inv_req),
      .i_stall        (i_stall),
      .cpu_inst_rdata (cpu_inst_rdata),
      .inv_busy       (inv_busy),
      .bus_err        (bus_err),
      .i_araddr       (i_araddr),
      .i_arlen        (i_arlen),
      .i_arsize       (i_arsize),
      .i_arburst      (i_arburst),
      .i_arvalid      (i_arvalid),
      .i_arready      (i_arready),
      .i_rdata        (i_rdata),
      .i_rresp        (i_rresp),
      .i_rlast        (i_rlast),
      .i_rvalid       (i_rvalid),
      .i_rready       (i_rready)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // AXI read slave: burst data is beat_base + beat number, one beat may carry SLVERR.
   logic [31:0] beat_base = 32'h0;
   int          err_beat = -1;
   int          ar_count = 0;
   logic [31:0] last_araddr = 32'h0;
   logic [7:0]  last_arlen = 8'h0;
   int          beats_left = 0;
   int          beat_idx = 0;
   bit          ar_hs = 1'b0;
   bit          r_hs = 1'b0;

   initial begin : axi_slave
      i_arready = 1'b1;
      i_rvalid  = 1'b0;
      i_rdata   = 32'h0;
      i_rresp   = 2'b00;
      i_rlast   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            beats_left = 0;
            ar_hs      = 1'b0;
            r_hs       = 1'b0;
         end else begin
            if (r_hs) begin
               beat_idx++;
               beats_left--;
            end
            if (ar_hs) begin
               beats_left = int'(last_arlen) + 1;
               beat_idx   = 0;
            end
         end
         i_rvalid = (beats_left > 0);
         i_rdata  = beat_base + 32'(beat_idx);
         i_rresp  = ((beats_left > 0) && (beat_idx == err_beat)) ? 2'b10 : 2'b00;
         i_rlast  = (beats_left == 1);
         // DUT handshake outputs depend only on state, so they are settled here.
         ar_hs = i_arvalid && i_arready && !rst;
         r_hs  = i_rvalid && i_rready && !rst;
         if (ar_hs) begin
            ar_count++;
            last_araddr = i_araddr;
            last_arlen  = i_arlen;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      cpu_inst_en = 1'b0;
      no_cache    = 1'b0;
      freeze      = 1'b0;
      inv_req     = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One fetch; returns the word, the number of stalled cycles and bus_err at completion.
   task automatic fetch(input logic [31:0] a, input logic nc, output logic [31:0] data,
                        output int stalls, output logic berr);
      @(negedge clk);
      cpu_inst_en   = 1'b1;
      cpu_inst_addr = a;
      no_cache      = nc;
      @(negedge clk);
      cpu_inst_en = 1'b0;
      no_cache    = 1'b0;
      stalls      = 0;
      while (i_stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      data = cpu_inst_rdata;
      berr = bus_err;
   endtask

   logic [31:0] d;
   int          st;
   logic        be;
   int          c0;
   int          busy;

   initial begin
      rst           = 1'b1;
      cpu_inst_en   = 1'b0;
      cpu_inst_addr = 32'h0;
      no_cache      = 1'b0;
      freeze        = 1'b0;
      inv_req       = 1'b0;
      do_reset();

      check_eq("rst_stall", 32'(i_stall), 32'd0);
      check_eq("rst_arvalid", 32'(i_arvalid), 32'd0);
      check_eq("rst_rready", 32'(i_rready), 32'd0);
      check_eq("rst_inv_busy", 32'(inv_busy), 32'd0);
      check_eq("rst_bus_err", 32'(bus_err), 32'd0);
      check_eq("rst_rdata", cpu_inst_rdata, 32'h0);

      // Cold miss then hit on the same word
      beat_base = 32'hA0;
      err_beat  = -1;
      c0        = ar_count;
      fetch(32'h0000_1004, 1'b0, d, st, be);
      check_eq("cold_araddr", last_araddr, 32'h0000_1000);
      check_eq("cold_arlen", 32'(last_arlen), 32'd7);
      check_eq("cold_stall", st, 32'd10);
      check_eq("cold_rdata", d, 32'hA1);
      check_eq("cold_ar_count", ar_count, c0 + 1);
      c0 = ar_count;
      fetch(32'h0000_1004, 1'b0, d, st, be);
      check_eq("hit_stall", st, 32'd0);
      check_eq("hit_rdata", d, 32'hA1);
      check_eq("hit_no_ar", ar_count, c0);

      // Five tags into set 0; tag 1 ends up as the PLRU victim
      do_reset();
      for (int t = 1; t <= 5; t++) begin
         beat_base = 32'h100 * 32'(t);
         c0        = ar_count;
         fetch(32'(t) << 12, 1'b0, d, st, be);
         check_eq($sformatf("fill%0d_rdata", t), d, 32'h100 * 32'(t));
         check_eq($sformatf("fill%0d_ar", t), ar_count, c0 + 1);
      end
      c0 = ar_count;
      fetch(32'h0000_5000, 1'b0, d, st, be);
      check_eq("tag5_hit_stall", st, 32'd0);
      check_eq("tag5_hit_rdata", d, 32'h500);
      beat_base = 32'h1100;
      fetch(32'h0000_1000, 1'b0, d, st, be);
      check_eq("tag1_miss_ar", ar_count, c0 + 1);
      check_eq("tag1_miss_rdata", d, 32'h1100);
      c0 = ar_count;
      fetch(32'h0000_2000, 1'b0, d, st, be);
      check_eq("tag2_hit_no_ar", ar_count, c0);
      check_eq("tag2_hit_rdata", d, 32'h200);
      beat_base = 32'h3300;
      fetch(32'h0000_3000, 1'b0, d, st, be);
      check_eq("tag3_evicted_ar", ar_count, c0 + 1);
      check_eq("tag3_evicted_stall", st, 32'd10);

      // Uncached fetch never allocates
      do_reset();
      beat_base = 32'hDEAD_BEEF;
      c0        = ar_count;
      fetch(32'h1FC0_0008, 1'b1, d, st, be);
      check_eq("nc_araddr", last_araddr, 32'h1FC0_0008);
      check_eq("nc_arlen", 32'(last_arlen), 32'd0);
      check_eq("nc_rdata", d, 32'hDEAD_BEEF);
      check_eq("nc_stall", st, 32'd3);
      fetch(32'h1FC0_0008, 1'b1, d, st, be);
      check_eq("nc_again_ar", ar_count, c0 + 2);

      // Refill with a bad beat leaves the line invalid
      do_reset();
      beat_base = 32'hB0;
      err_beat  = 3;
      c0        = ar_count;
      fetch(32'h0000_2000, 1'b0, d, st, be);
      check_eq("err_bus_err", 32'(be), 32'd1);
      check_eq("err_rdata", d, 32'hB0);
      @(negedge clk);
      check_eq("err_pulse_end", 32'(bus_err), 32'd0);
      err_beat = -1;
      fetch(32'h0000_2000, 1'b0, d, st, be);
      check_eq("err_refetch_ar", ar_count, c0 + 2);
      check_eq("err_refetch_bus_err", 32'(be), 32'd0);

      // Invalidate after a fill
      do_reset();
      beat_base = 32'hA0;
      fetch(32'h0000_1004, 1'b0, d, st, be);
      check_eq("inv_fill_rdata", d, 32'hA1);
      fetch(32'h0000_1004, 1'b0, d, st, be);
      check_eq("inv_pre_hit_stall", st, 32'd0);
      @(negedge clk);
      inv_req = 1'b1;
      @(negedge clk);
      inv_req = 1'b0;
      busy    = 0;
      while (inv_busy && busy < 300) begin
         busy++;
         @(negedge clk);
      end
      check_eq("inv_busy_cycles", busy, 32'd128);
      beat_base = 32'hC0;
      c0        = ar_count;
      fetch(32'h0000_1004, 1'b0, d, st, be);
      check_eq("inv_refetch_ar", ar_count, c0 + 1);
      check_eq("inv_refetch_rdata", d, 32'hC1);
`ifdef I_CACHE_PERF_EN
      check_eq("perf_hit_cnt", hit_cnt, 32'd1);
      check_eq("perf_miss_cnt", miss_cnt, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
